// File: rtl/std_cache_pkg.sv
// Shared types for the write-back dcache: arbitration FSM states used by the
// access arbiter that serialises CPU and snoop access to the tag/state SRAMs.
package std_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dcache_rr_pick.sv
// Combinational round-robin picker: finds the first requesting CPU port at or
// after ptr_i, wrapping modulo NR_CPU_PORTS. Holds no state; the parent owns
// the pointer and decides whether the pick is actually granted.
module dcache_rr_pick #(
    parameter int NR_CPU_PORTS = 3,
    parameter int PTR_W        = (NR_CPU_PORTS > 1) ? $clog2(NR_CPU_PORTS) : 1
) (
    input  logic [NR_CPU_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]        ptr_i,
    output logic [NR_CPU_PORTS-1:0] gnt_o,
    output logic                    vld_o
);

    // Walk ports in priority order starting at the pointer; first requester wins.
    always_comb begin
        logic found;
        int   pos;
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NR_CPU_PORTS; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NR_CPU_PORTS) begin
                pos = pos - NR_CPU_PORTS;
            end
            for (int k = 0; k < NR_CPU_PORTS; k++) begin
                if (!found && (k == pos) && req_i[k]) begin
                    gnt_o[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/dcache_access_arbiter.sv
// Grants exclusive use of the dcache tag and valid/dirty/shared SRAM sequence
// to one requester at a time: CPU ports (round-robin) or the ACE snoop channel.
// Snoops win by default; after STARVE_LIMIT consecutive snoop wins against a
// pending CPU request, a CPU port is served. The grant is held until done_i.
module dcache_access_arbiter
    import std_cache_pkg::*;
#(
    parameter int NR_CPU_PORTS = 3,
    parameter int STARVE_LIMIT = 8,
    parameter int OWNER_W      = $clog2(NR_CPU_PORTS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NR_CPU_PORTS-1:0] cpu_req_i,
    output logic [NR_CPU_PORTS-1:0] cpu_gnt_o,
    input  logic                    snoop_req_i,
    output logic                    snoop_gnt_o,
    input  logic                    done_i,
    output logic                    busy_o,
    output logic [OWNER_W-1:0]      owner_o,
    output logic                    err_o
);

    localparam int PTR_W    = (NR_CPU_PORTS > 1) ? $clog2(NR_CPU_PORTS) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [OWNER_W-1:0]  SNOOP_OWNER = OWNER_W'(NR_CPU_PORTS);
    localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]    LAST_PORT   = PTR_W'(NR_CPU_PORTS - 1);

    arb_state_e              state_q, state_d;
    logic [OWNER_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                    err_q, err_d;

    logic [NR_CPU_PORTS-1:0] pick_gnt;
    logic                    pick_vld;
    logic [PTR_W-1:0]        pick_idx;
    logic [NR_CPU_PORTS-1:0] cpu_gnt;
    logic                    snoop_gnt;
    logic                    snoop_wins;
    logic                    cpu_wins;

    dcache_rr_pick #(
        .NR_CPU_PORTS (NR_CPU_PORTS),
        .PTR_W        (PTR_W)
    ) u_rr_pick (
        .req_i (cpu_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    // Convert the one-hot round-robin pick into a port index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NR_CPU_PORTS; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Winner selection, grant pulses and next-state for all arbiter state.
    always_comb begin
        // A snoop only beats a pending CPU request while the starvation budget
        // lasts, so starve_cnt never increments past STARVE_MAX.
        snoop_wins   = snoop_req_i && (!pick_vld || (starve_cnt_q < STARVE_MAX));
        cpu_wins     = pick_vld && !snoop_wins;

        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        cpu_gnt      = '0;
        snoop_gnt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (done_i) begin
                    err_d = 1'b1;
                end
                if (snoop_wins) begin
                    snoop_gnt    = 1'b1;
                    owner_d      = SNOOP_OWNER;
                    state_d      = BUSY;
                    starve_cnt_d = pick_vld ? (starve_cnt_q + STARVE_W'(1)) : '0;
                end else if (cpu_wins) begin
                    cpu_gnt      = pick_gnt;
                    owner_d      = OWNER_W'(pick_idx);
                    state_d      = BUSY;
                    starve_cnt_d = '0;
                    rr_ptr_d     = (pick_idx == LAST_PORT) ? '0 : (pick_idx + PTR_W'(1));
                end
            end
            BUSY: begin
                if (done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers; reset is asynchronous so a mid-BUSY reset frees the resource at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    // Grants are combinational from IDLE, so they are also masked while reset is held.
    assign cpu_gnt_o   = rst_i ? '0 : cpu_gnt;
    assign snoop_gnt_o = rst_i ? 1'b0 : snoop_gnt;
    assign busy_o      = (state_q == BUSY);
    assign owner_o     = owner_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dcache_access_arbiter.sv
// Directed bench for dcache_access_arbiter with a grant scoreboard.
module tb_dcache_access_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] cpu_req_i;
    logic [2:0] cpu_gnt_o;
    logic       snoop_req_i;
    logic       snoop_gnt_o;
    logic       done_i;
    logic       busy_o;
    logic [1:0] owner_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] cpu;
        logic       snp;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];

    dcache_access_arbiter #(
        .NR_CPU_PORTS (3),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_gnt_o   (cpu_gnt_o),
        .snoop_req_i (snoop_req_i),
        .snoop_gnt_o (snoop_gnt_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push the expected grant, present the requests, then check the grant,
    // the BUSY phase (no grants, owner held) and the return to IDLE.
    task automatic txn(input string tag, input logic [2:0] cpu, input logic snp,
                       input logic [2:0] e_cpu, input logic e_snp, input logic [1:0] e_own);
        exp_t e;
        sb.push_back('{cpu: e_cpu, snp: e_snp, own: e_own});
        cpu_req_i   = cpu;
        snoop_req_i = snp;
        @(negedge clk_i);
        e = sb.pop_front();
        chk({tag, "_gnt"}, {28'd0, cpu_gnt_o, snoop_gnt_o}, {28'd0, e.cpu, e.snp});
        chk({tag, "_onehot"}, 32'($countones({cpu_gnt_o, snoop_gnt_o}) <= 1), 32'd1);
        @(posedge clk_i); #1;
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_owner"}, 32'(owner_o), 32'(e.own));
        done_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_busy_nogrant"}, {28'd0, cpu_gnt_o, snoop_gnt_o}, 32'd0);
        @(posedge clk_i); #1;
        done_i = 1'b0;
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
        chk({tag, "_owner_hold"}, 32'(owner_o), 32'(e.own));
    endtask

    initial begin
        exp_t e;
        rst_i       = 1'b1;
        cpu_req_i   = 3'b000;
        snoop_req_i = 1'b0;
        done_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_gnt", {28'd0, cpu_gnt_o, snoop_gnt_o}, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_noreq", {28'd0, cpu_gnt_o, snoop_gnt_o}, 32'd0);

        // Round-robin with all ports held.
        txn("rr0", 3'b111, 1'b0, 3'b001, 1'b0, 2'd0);
        txn("rr1", 3'b111, 1'b0, 3'b010, 1'b0, 2'd1);
        txn("rr2", 3'b111, 1'b0, 3'b100, 1'b0, 2'd2);
        txn("rr3", 3'b111, 1'b0, 3'b001, 1'b0, 2'd0);

        // Snoop beats a pending CPU request; then a CPU grant clears starve_cnt.
        txn("snp_pri", 3'b001, 1'b1, 3'b000, 1'b1, 2'd3);
        txn("cpu_only", 3'b001, 1'b0, 3'b001, 1'b0, 2'd0);

        // Starvation guard: 8 snoop wins, then port 2, then snoop again.
        for (int i = 0; i < 8; i++) begin
            txn($sformatf("starve_snp%0d", i), 3'b100, 1'b1, 3'b000, 1'b1, 2'd3);
        end
        txn("starve_cpu", 3'b100, 1'b1, 3'b100, 1'b0, 2'd2);
        txn("starve_after", 3'b100, 1'b1, 3'b000, 1'b1, 2'd3);

        // Spurious done in IDLE sets sticky err_o without leaving IDLE.
        cpu_req_i   = 3'b000;
        snoop_req_i = 1'b0;
        done_i      = 1'b1;
        @(posedge clk_i); #1;
        done_i = 1'b0;
        chk("spur_err", 32'(err_o), 32'd1);
        chk("spur_idle", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("spur_err_sticky", 32'(err_o), 32'd1);
        txn("spur_then_grant", 3'b010, 1'b0, 3'b010, 1'b0, 2'd1);
        chk("err_still", 32'(err_o), 32'd1);

        // Reset in the middle of BUSY.
        sb.push_back('{cpu: 3'b010, snp: 1'b0, own: 2'd1});
        cpu_req_i = 3'b010;
        @(negedge clk_i);
        e = sb.pop_front();
        chk("mid_gnt", {28'd0, cpu_gnt_o, snoop_gnt_o}, {28'd0, e.cpu, e.snp});
        @(posedge clk_i); #1;
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_owner", 32'(owner_o), 32'(e.own));
        cpu_req_i = 3'b111;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_owner", 32'(owner_o), 32'd0);
        chk("mid_rst_gnt", {28'd0, cpu_gnt_o, snoop_gnt_o}, 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        txn("post_rst", 3'b111, 1'b0, 3'b001, 1'b0, 2'd0);
        txn("post_rst2", 3'b111, 1'b0, 3'b010, 1'b0, 2'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_access_arbiter.md
# dcache_access_arbiter

Arbitrates between the CPU request ports and the ACE snoop channel for exclusive use of the write-back dcache's tag and valid/dirty/shared SRAM sequence. The block sits in front of the dcache controllers. It grants one owner at a time and holds the grant until that owner signals completion. Snoops normally have priority, with a starvation guard so CPU ports still make progress. CPU ports are served round-robin.

## Interface
Parameters:
- NR_CPU_PORTS, 3, number of CPU requesters (≥1)
- STARVE_LIMIT, 8, consecutive snoop grants allowed while any CPU request is pending (≥1)
- OWNER_W, $clog2(NR_CPU_PORTS+1), owner encoding width

Ports (reset is asynchronous, active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cpu_req_i  in  NR_CPU_PORTS  level request per CPU port, held until granted
- cpu_gnt_o  out  NR_CPU_PORTS  one-hot grant pulse
- snoop_req_i  in  1  level snoop request, held until granted
- snoop_gnt_o  out  1  snoop grant pulse
- done_i  in  1  current owner finished its SRAM sequence
- busy_o  out  1  an owner holds the resource
- owner_o  out  OWNER_W  current owner: 0..NR_CPU_PORTS-1 = CPU port, NR_CPU_PORTS = snoop
- err_o  out  1  sticky: done_i seen while idle

## Operation
- FSM states: IDLE, BUSY.
- IDLE with no requests: stay in IDLE, all grants 0.
- IDLE with any request: pick a winner combinationally, pulse its grant in the same cycle, latch owner_o, and go to BUSY on the next edge.
- BUSY: all grants 0 and new requests are ignored. When done_i = 1, go to IDLE on the next edge, so at least one IDLE cycle separates two grants.
- Winner selection:
  - No CPU request pending: snoop wins if requesting.
  - Snoop and a CPU request both pending, starve_cnt < STARVE_LIMIT: snoop wins and starve_cnt increments.
  - Snoop and a CPU request both pending, starve_cnt == STARVE_LIMIT: a CPU port wins.
  - Only CPU requests pending: a CPU port wins.
- starve_cnt:
  - Resets to 0 on any CPU grant.
  - Resets to 0 on a snoop grant while no CPU request is pending.
  - Saturates at STARVE_LIMIT; width $clog2(STARVE_LIMIT+1).
- CPU round-robin:
  - Pointer rr_ptr; search starts at rr_ptr and wraps modulo NR_CPU_PORTS.
  - After a grant to port p, rr_ptr = (p+1) mod NR_CPU_PORTS; wrap from NR_CPU_PORTS-1 to 0.
  - A snoop grant leaves rr_ptr unchanged.
- err_o is set by done_i in IDLE and cleared only by reset. done_i in IDLE does not change the FSM.
- A requester deasserting its request before grant is legal; it is simply not granted.

## Timing
- Reset values: state IDLE, busy_o 0, owner_o 0, cpu_gnt_o 0, snoop_gnt_o 0, err_o 0, rr_ptr 0, starve_cnt 0.
- Reset takes effect asynchronously, including mid-BUSY; grants drop immediately.
- Grant latency: 0 cycles from request in IDLE (combinational). busy_o rises 1 cycle after the grant.
- owner_o is registered, valid while busy_o = 1, and holds its last value while idle.
- Minimum request-to-request spacing: grant cycle + BUSY cycles until done_i + 1 IDLE cycle.
- At most one grant bit is high in any cycle.

## Structure
- Add arb_state_e {IDLE, BUSY} to std_cache_pkg. Owner encoding is derived in-module from the parameter.
- Sub-module dcache_rr_pick: combinational round-robin pick over NR_CPU_PORTS given rr_ptr. Outputs are a one-hot grant and a valid bit. All state stays in the parent.

## Test plan
- Reset mid-BUSY: grant port 1, assert rst_i one cycle later -> busy_o = 0, owner_o = 0 and grants 0 immediately. After release, port 0 is granted first.
- Round-robin: cpu_req_i = 3'b111 held, done_i pulsed each BUSY cycle -> grants in order port0, port1, port2, port0 (wrap).
- Snoop priority: snoop_req_i = 1 and cpu_req_i = 3'b001 in IDLE -> snoop_gnt_o pulses and owner_o = 3 next cycle.
- Starvation, STARVE_LIMIT = 8: snoop and port 2 requesting continuously -> 8 snoop grants, then cpu_gnt_o = 3'b100, then snoop again.
- Spurious done: done_i = 1 in IDLE -> err_o = 1 and stays 1, FSM stays IDLE. Only reset clears err_o.
- Back-to-back: done_i with new requests already pending -> one IDLE cycle, then grant. Grants are never in consecutive cycles, and no cycle has more than one grant bit high.
